texel_disassembler: RTL and testbench

Transmit-side counterpart of the texel assembler. Accepts one 168-bit texel record from the texel pipeline and serializes it into a framed stream of 32-bit words for the AHB user buffer. Each frame is FRAME_START, six payload words, then FRAME_END. The block sits between the texel producer and the AHB master's write FIFO; its word stream is exactly what the assembler consumes.

---
 rtl/texel_disassembler_if.sv | 20 ++
 rtl/texel_disassembler.sv | 132 +++++++++++++
 tb/tb_texel_disassembler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/texel_disassembler_if.sv
// Texel-in / AHB-word-out handshake bundle shared by the disassembler and its driver.
// master = producer/AHB side, slave = disassembler side.
interface texel_disassembler_if;
    logic [167:0] texel_buffer;
    logic         texel_ready;
    logic         texel_read;
    logic [31:0]  ahb_buffer;
    logic         ahb_data_available;
    logic         ahb_user_read_buffer;

    modport master (
        output texel_buffer, texel_ready, ahb_user_read_buffer,
        input  texel_read, ahb_buffer, ahb_data_available
    );

    modport slave (
        input  texel_buffer, texel_ready, ahb_user_read_buffer,
        output texel_read, ahb_buffer, ahb_data_available
    );
endinterface

// File: rtl/texel_disassembler.sv
// Serializes a 168-bit texel into START, 6 payload words, [CSUM if TEXEL_TX_CHECKSUM_EN], END.
// Accept in N -> FRAME_START valid in N+1; each word holds until popped, so stalls of any length are safe.
module texel_disassembler #(
    parameter logic [31:0] FRAME_START = 32'h0000_0000,
    parameter logic [31:0] FRAME_END   = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 rst,
    texel_disassembler_if.slave  tx
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        PAYLOAD,
        END
`ifdef TEXEL_TX_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [167:0]  hold_q, hold_d;
    logic [31:0]   word_q, word_d;
    logic          avail_q, avail_d;
    logic          pop;
    logic          accept;

    // Word shown for a given (state, index, hold); outputs are registered from this.
    function automatic logic [31:0] word_of(state_t s, logic [2:0] k, logic [167:0] h);
        logic [31:0] w;
        w = 32'h0;
        case (s)
            START:   w = FRAME_START;
            PAYLOAD: begin
                case (k)
                    3'd0:    w = h[31:0];
                    3'd1:    w = h[63:32];
                    3'd2:    w = h[95:64];
                    3'd3:    w = h[127:96];
                    3'd4:    w = h[159:128];
                    default: w = {24'h0, h[167:160]};
                endcase
            end
`ifdef TEXEL_TX_CHECKSUM_EN
            CSUM:    w = h[31:0] ^ h[63:32] ^ h[95:64] ^ h[127:96] ^ h[159:128]
                         ^ {24'h0, h[167:160]};
`endif
            END:     w = FRAME_END;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    assign pop = avail_q & tx.ahb_user_read_buffer;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx.texel_ready) begin
                    accept  = 1'b1;
                    hold_d  = tx.texel_buffer;
                    state_d = START;
                end
            end
            START: begin
                if (pop) begin
                    state_d = PAYLOAD;
                    idx_d   = 3'd0;
                end
            end
            PAYLOAD: begin
                if (pop) begin
                    if (idx_q == 3'd5) begin
                        idx_d = 3'd0;
`ifdef TEXEL_TX_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = END;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef TEXEL_TX_CHECKSUM_EN
            CSUM: begin
                if (pop) state_d = END;
            end
`endif
            END: begin
                if (pop) begin
                    if (tx.texel_ready) begin
                        accept  = 1'b1;
                        hold_d  = tx.texel_buffer;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        word_d  = word_of(state_d, idx_d, hold_d);
        avail_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            hold_q  <= 168'h0;
            word_q  <= 32'h0;
            avail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            word_q  <= word_d;
            avail_q <= avail_d;
        end
    end

    // Reset wins over an accept in the same cycle.
    assign tx.texel_read         = accept & ~rst;
    assign tx.ahb_buffer         = word_q;
    assign tx.ahb_data_available = avail_q;
endmodule

// File: tb/tb_texel_disassembler.sv
// Directed and random stimulus against a word-queue model of the framed output stream.
module tb_texel_disassembler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    texel_disassembler_if tif ();

    texel_disassembler dut (
        .clk (clk),
        .rst (rst),
        .tx  (tif)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Words still to be emitted by the current frame; front is what the DUT should show.
    logic [31:0] q[$];

    function automatic logic [167:0] rand_texel();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[167:0];
    endfunction

    task automatic push_frame(input logic [167:0] t);
        logic [31:0] w;
        logic [31:0] cs;
        cs = 32'h0;
        q.push_back(32'h0000_0000);
        for (int k = 0; k < 6; k++) begin
            if (k < 5) w = t[32*k +: 32];
            else       w = {24'h0, t[167:160]};
            cs = cs ^ w;
            q.push_back(w);
        end
`ifdef TEXEL_TX_CHECKSUM_EN
        q.push_back(cs);
`endif
        q.push_back(32'h0000_0001);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare 1ns later, then advance the model to the next posedge.
    task automatic step(input logic r, input logic rdy, input logic [167:0] b,
                        input logic rd, input bit chk);
        logic        exp_avail;
        logic [31:0] exp_buf;
        logic        exp_pop;
        logic        exp_acc;
        @(negedge clk);
        rst                      = r;
        tif.texel_ready          = rdy;
        tif.texel_buffer         = b;
        tif.ahb_user_read_buffer = rd;
        #1;
        exp_avail = (q.size() != 0);
        exp_buf   = exp_avail ? q[0] : 32'h0;
        exp_pop   = exp_avail && rd;
        exp_acc   = !r && rdy && (q.size() == 0 || (q.size() == 1 && exp_pop));
        if (chk) begin
            check("texel_read", {31'h0, tif.texel_read}, {31'h0, exp_acc});
            check("avail", {31'h0, tif.ahb_data_available}, {31'h0, exp_avail});
            check("ahb_buffer", tif.ahb_buffer, exp_buf);
        end
        if (r) begin
            q.delete();
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_acc) push_frame(b);
        end
    endtask

    logic [167:0] t1, t2, t3;

    initial begin
        rst                      = 1'b1;
        tif.texel_ready          = 1'b1;
        tif.texel_buffer         = '0;
        tif.ahb_user_read_buffer = 1'b0;
        t1 = {8'hAB, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};

        // Reset held with texel_ready high: nothing accepted, outputs quiet.
        step(1'b1, 1'b1, t1, 1'b0, 1'b0);
        step(1'b1, 1'b1, t1, 1'b1, 1'b1);
        step(1'b1, 1'b1, t1, 1'b1, 1'b1);

        // Single frame with continuous pops; input changes after accept.
        step(1'b0, 1'b1, t1, 1'b1, 1'b1);
        repeat (11) step(1'b0, 1'b0, rand_texel(), 1'b1, 1'b1);

        // Stall three cycles on payload k=2.
        step(1'b0, 1'b1, t1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, t1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, t1, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0, t1, 1'b1, 1'b1);

        // Back-to-back frames with texel_ready held high.
        t2 = rand_texel();
        t3 = rand_texel();
        step(1'b0, 1'b1, t2, 1'b1, 1'b1);
        repeat (9) step(1'b0, 1'b1, t3, 1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b0, rand_texel(), 1'b1, 1'b1);

        // Reset at payload k=3, then a fresh frame.
        step(1'b0, 1'b1, rand_texel(), 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0, rand_texel(), 1'b1, 1'b1);
        step(1'b1, 1'b0, rand_texel(), 1'b1, 1'b1);
        step(1'b0, 1'b0, rand_texel(), 1'b1, 1'b1);
        step(1'b0, 1'b1, rand_texel(), 1'b1, 1'b1);
        repeat (11) step(1'b0, 1'b0, rand_texel(), 1'b1, 1'b1);

        // Random traffic: sporadic reset, bursty ready and pops, input churning every cycle.
        repeat (500) step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                          rand_texel(), $urandom_range(0, 3) != 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
